control_sequencer: RTL and testbench

//  T-state sequencer and instruction decoder of the 8-bit computer. Sits directly downstream of

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/control_sequencer_t_ring.sv | 54 +++++
 rtl/control_sequencer.sv | 81 ++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer's control path: opcodes,
// control-word bit positions and the T-state encoding.
package cpu_pkg;

  localparam int OPC_W_DEF = 4;
  localparam int CW_W_DEF  = 12;

  // Opcodes carried in IR[7:4]
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions, one enable per bus driver / register load
  localparam int CB_PC_INC   = 0;
  localparam int CB_PC_OUT   = 1;
  localparam int CB_MAR_LOAD = 2;
  localparam int CB_RAM_OUT  = 3;
  localparam int CB_IR_LOAD  = 4;
  localparam int CB_IR_OUT   = 5;
  localparam int CB_A_LOAD   = 6;
  localparam int CB_A_OUT    = 7;
  localparam int CB_B_LOAD   = 8;
  localparam int CB_ALU_OUT  = 9;
  localparam int CB_ALU_SUB  = 10;
  localparam int CB_OUT_LOAD = 11;

  // T-state encoding doubles as the externally visible t_state value
  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } state_e;

  // Opcodes whose T4 loads the MAR from the IR operand field
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/control_sequencer_t_ring.sv
// Six-state T-counter: holds in T1 until run, leaves T4 to HALT on request,
// and stays in HALT until reset.
module t_ring
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   run_i,
  input  logic   halt_i,
  output state_e state_o,
  output logic   halted_o
);

  state_e state_q;
  logic   halted_q;

  // Ring advance with T1 hold, HLT exit from T4, and absorbing HALT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_T1;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_T1: begin
          if (run_i) state_q <= ST_T2;
        end
        ST_T2: state_q <= ST_T3;
        ST_T3: state_q <= ST_T4;
        ST_T4: begin
          if (halt_i) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_T5;
          end
        end
        ST_T5: state_q <= ST_T6;
        ST_T6: state_q <= ST_T1;
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_T1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_o  = state_q;
  assign halted_o = halted_q;

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer and instruction decoder: fetch through MAR/RAM into IR,
// then one control word per T-state for A, B, ALU and output register.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int CW_W  = CW_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  output logic [CW_W-1:0]  ctrl,
  output logic [2:0]       t_state,
  output logic             halted
);

  state_e          state;
  logic [CW_W-1:0] cw;
  logic [3:0]      op;

  assign op = opcode[3:0];

  t_ring u_ring (
    .clk      (clk),
    .reset_n  (reset_n),
    .run_i    (run),
    .halt_i   (op == OP_HLT),
    .state_o  (state),
    .halted_o (halted)
  );

  // Control word from the current T-state and the IR opcode
  always_comb begin
    cw = '0;
    unique case (state)
      ST_T1: begin
        if (run) begin
          cw[CB_PC_OUT]   = 1'b1;
          cw[CB_MAR_LOAD] = 1'b1;
        end
      end
      ST_T2: cw[CB_PC_INC] = 1'b1;
      ST_T3: begin
        cw[CB_RAM_OUT] = 1'b1;
        cw[CB_IR_LOAD] = 1'b1;
      end
      ST_T4: begin
        if (is_mem_op(op)) begin
          cw[CB_IR_OUT]   = 1'b1;
          cw[CB_MAR_LOAD] = 1'b1;
        end else if (op == OP_OUT) begin
          cw[CB_A_OUT]    = 1'b1;
          cw[CB_OUT_LOAD] = 1'b1;
        end
      end
      ST_T5: begin
        if (op == OP_LDA) begin
          cw[CB_RAM_OUT] = 1'b1;
          cw[CB_A_LOAD]  = 1'b1;
        end else if ((op == OP_ADD) || (op == OP_SUB)) begin
          cw[CB_RAM_OUT] = 1'b1;
          cw[CB_B_LOAD]  = 1'b1;
        end
      end
      ST_T6: begin
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          cw[CB_ALU_OUT] = 1'b1;
          cw[CB_A_LOAD]  = 1'b1;
          cw[CB_ALU_SUB] = (op == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
  end

  // Reset forces an idle word immediately, even while run is high in T1
  assign ctrl    = reset_n ? cw : '0;
  assign t_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: microprogram-table model, per-cycle compare,
// directed literal checks and randomized run/opcode/reset stimulus.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [11:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;

  control_sequencer #(.OPC_W(4), .CW_W(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .opcode  (opcode),
    .ctrl    (ctrl),
    .t_state (t_state),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_t     = 1;     // model T-state, 0 = HALT
  int pulses  = 0;     // pc_inc pulses since last reset
  int pc      = 0;     // 4-bit program counter driven by pc_inc

  // literal expectation requests, consumed by the compare process
  int          lit_seq  = 0;
  int          lit_seen = 0;
  int          lit_kind = 0;
  string       lit_name = "";
  logic [11:0] lit_ctrl = '0;
  int          lit_t    = 0;
  logic        lit_h    = 1'b0;

  // Per-instruction execute words for T4, T5, T6
  function automatic logic [11:0] exec_word(input logic [3:0] op, input int step);
    logic [11:0] w [3];
    case (op)
      4'h0:    w = '{12'h024, 12'h048, 12'h000};
      4'h1:    w = '{12'h024, 12'h108, 12'h240};
      4'h2:    w = '{12'h024, 12'h108, 12'h640};
      4'hE:    w = '{12'h880, 12'h000, 12'h000};
      default: w = '{12'h000, 12'h000, 12'h000};
    endcase
    return w[step];
  endfunction

  function automatic logic [11:0] exp_ctrl(input int t, input logic r,
                                            input logic [3:0] op, input logic rn);
    if (!rn) return 12'h000;
    if (t == 0) return 12'h000;
    if (t == 1) return r ? 12'h006 : 12'h000;
    if (t == 2) return 12'h001;
    if (t == 3) return 12'h018;
    return exec_word(op, t - 4);
  endfunction

  function automatic int next_t(input int t, input logic r, input logic [3:0] op);
    if (t == 0) return 0;
    if (t == 1) return r ? 2 : 1;
    if (t == 4 && op == 4'hF) return 0;
    if (t == 6) return 1;
    return t + 1;
  endfunction

  // model state update
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) m_t = 1;
    else          m_t = next_t(m_t, run, opcode);
  end

  // the single compare process
  initial forever begin : cmp
    logic [11:0] e;
    @(negedge clk);
    e = exp_ctrl(m_t, run, opcode, reset_n);
    n_tests++;
    if (ctrl !== e) begin
      n_fail++;
      $display("FAIL model_ctrl t=%0d op=%h run=%b: got %h want %h", m_t, opcode, run, ctrl, e);
    end
    n_tests++;
    if (t_state !== m_t[2:0] || halted !== (m_t == 0)) begin
      n_fail++;
      $display("FAIL model_state: got t=%0d h=%b want t=%0d h=%b", t_state, halted, m_t, (m_t == 0));
    end
    n_tests++;
    if ($countones(ctrl & 12'h2AA) > 1 || (ctrl[10] && !ctrl[9])) begin
      n_fail++;
      $display("FAIL bus_excl: ctrl=%h has >1 driver or alu_sub without alu_out", ctrl);
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_tests++;
      if (lit_kind == 0) begin
        if (ctrl !== lit_ctrl || t_state !== lit_t[2:0] || halted !== lit_h) begin
          n_fail++;
          $display("FAIL %s: got ctrl=%h t=%0d h=%b want ctrl=%h t=%0d h=%b",
                   lit_name, ctrl, t_state, halted, lit_ctrl, lit_t, lit_h);
        end
      end else begin
        if (pulses != lit_t || pc != int'(lit_ctrl)) begin
          n_fail++;
          $display("FAIL %s: got pulses=%0d pc=%0d want pulses=%0d pc=%0d",
                   lit_name, pulses, pc, lit_t, lit_ctrl);
        end
      end
    end
    if (!reset_n) begin
      pulses = 0;
      pc     = 0;
    end else if (ctrl[0]) begin
      pulses++;
      pc = (pc + 1) % 16;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [11:0] ec, input int et, input logic eh);
    lit_kind = 0;
    lit_name = name;
    lit_ctrl = ec;
    lit_t    = et;
    lit_h    = eh;
    lit_seq++;
  endtask

  task automatic lit_pc(input string name, input int exp_pulses, input int exp_pc);
    lit_kind = 1;
    lit_name = name;
    lit_ctrl = 12'(exp_pc);
    lit_t    = exp_pulses;
    lit_h    = 1'b0;
    lit_seq++;
  endtask

  // one full instruction starting in T1, ending back in T1
  task automatic instr(input string name, input logic [3:0] op,
                       input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    run = 1'b1;
    #1 lit({name, "_T1"}, 12'h006, 1, 1'b0);
    tick(); lit({name, "_T2"}, 12'h001, 2, 1'b0);
    tick(); lit({name, "_T3"}, 12'h018, 3, 1'b0);
    tick(); opcode = op;
    #1 lit({name, "_T4"}, e4, 4, 1'b0);
    tick(); lit({name, "_T5"}, e5, 5, 1'b0);
    tick(); lit({name, "_T6"}, e6, 6, 1'b0);
    tick();
  endtask

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 4'h0;
      1:       return 4'h1;
      2:       return 4'h2;
      3:       return 4'hE;
      4:       return 4'hF;
      5:       return 4'h7;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    // reset held with run high
    reset_n = 1'b0; run = 1'b1; opcode = 4'h0;
    tick(); lit("reset_hold", 12'h000, 1, 1'b0);
    tick(); lit("reset_hold2", 12'h000, 1, 1'b0);
    tick();
    reset_n = 1'b1;
    instr("lda", 4'h0, 12'h024, 12'h048, 12'h000);
    instr("add", 4'h1, 12'h024, 12'h108, 12'h240);
    instr("sub", 4'h2, 12'h024, 12'h108, 12'h640);
    instr("out", 4'hE, 12'h880, 12'h000, 12'h000);
    instr("undef7", 4'h7, 12'h000, 12'h000, 12'h000);

    // idle in T1
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 lit("idle", 12'h000, 1, 1'b0);
      tick();
    end

    // 16 instructions with a PC attached after a fresh reset
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      instr("pc_lda", 4'h0, 12'h024, 12'h048, 12'h000);
      if (i == 7) begin run = 1'b0; #1 lit_pc("pc_half", 8, 8); end
    end
    run = 1'b0;
    #1 lit_pc("pc_wrap", 16, 0);
    tick();

    // reset pulse in T5
    run = 1'b1; opcode = 4'h1;
    tick(); tick(); tick(); tick();
    lit("midop_T5", 12'h108, 5, 1'b0);
    tick();
    reset_n = 1'b0;
    #1 lit("midop_reset", 12'h000, 1, 1'b0);
    tick();
    reset_n = 1'b1; run = 1'b0;
    lit("after_reset", 12'h000, 1, 1'b0);
    tick();

    // HLT then 20 cycles of HALT regardless of inputs
    run = 1'b1;
    tick(); tick(); tick();
    opcode = 4'hF;
    #1 lit("hlt_T4", 12'h000, 4, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      #1 lit("halt_hold", 12'h000, 0, 1'b1);
      tick();
    end
    reset_n = 1'b0; tick(); reset_n = 1'b1;

    // randomized run / opcode / reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      run = ($urandom_range(0, 7) != 0);
      if (m_t == 4) opcode = pick_op();
      if ((m_t == 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        reset_n = 1'b0;
      else
        reset_n = 1'b1;
    end
    reset_n = 1'b1;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
